// File: rtl/alu_op_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_driver
// Brief    : Command FIFO and output register feeding an ALU push/stop port,
//            result FIFO with backpressure, in-flight tracking.
// Revision : 1.0  initial release
// ============================================================================
module alu_op_driver #(
    parameter int DW        = 8,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int MAX_OUT   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_ctl,
    input  logic [DW-1:0]                cmd_a,
    input  logic [DW-1:0]                cmd_b,
    input  logic                         cmd_ci,
    output logic                         pushin,
    input  logic                         stopout,
    output logic [1:0]                   ctl,
    output logic [DW-1:0]                a,
    output logic [DW-1:0]                b,
    output logic                         ci,
    input  logic                         pushout,
    output logic                         stopin,
    input  logic [DW-1:0]                z,
    input  logic                         cout,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [DW-1:0]                res_z,
    output logic                         res_cout,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         err_unexp
);

    localparam int c_CW  = 2 * DW + 3;
    localparam int c_RW  = DW + 1;
    localparam int c_CPW = $clog2(CMD_DEPTH);
    localparam int c_CCW = $clog2(CMD_DEPTH + 1);
    localparam int c_RPW = $clog2(RES_DEPTH);
    localparam int c_RCW = $clog2(RES_DEPTH + 1);
    localparam int c_OW  = $clog2(MAX_OUT + 1);

    localparam logic [c_CPW-1:0] c_CPTR_ONE = c_CPW'(1);
    localparam logic [c_CCW-1:0] c_CCNT_ONE = c_CCW'(1);
    localparam logic [c_CCW-1:0] c_CMD_FULL = c_CCW'(CMD_DEPTH);
    localparam logic [c_RPW-1:0] c_RPTR_ONE = c_RPW'(1);
    localparam logic [c_RCW-1:0] c_RCNT_ONE = c_RCW'(1);
    localparam logic [c_RCW-1:0] c_RES_FULL = c_RCW'(RES_DEPTH);
    localparam logic [c_OW-1:0]  c_OUT_ONE  = c_OW'(1);
    localparam logic [c_OW-1:0]  c_OUT_MAX  = c_OW'(MAX_OUT);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_load;
    logic              w_can_load;
    logic              w_cmd_push;
    logic              w_res_push;
    logic              w_res_pop;

    logic [c_CW-1:0]   r_cmd_mem [CMD_DEPTH];
    logic [c_CPW-1:0]  r_cmd_wp;
    logic [c_CPW-1:0]  r_cmd_rp;
    logic [c_CCW-1:0]  r_cmd_cnt;
    logic [c_CW-1:0]   w_cmd_head;

    logic [c_RW-1:0]   r_res_mem [RES_DEPTH];
    logic [c_RPW-1:0]  r_res_wp;
    logic [c_RPW-1:0]  r_res_rp;
    logic [c_RCW-1:0]  r_res_cnt;
    logic [c_RW-1:0]   w_res_head;

    logic [1:0]        r_ctl;
    logic [DW-1:0]     r_a;
    logic [DW-1:0]     r_b;
    logic              r_ci;
    logic [c_OW-1:0]   r_out;
    logic              r_err;

    // Ready flags come from registered counts only, so a same-cycle pop never frees a slot early.
    assign cmd_ready  = (r_cmd_cnt < c_CMD_FULL);
    assign stopin     = (r_res_cnt == c_RES_FULL);
    assign res_valid  = (r_res_cnt != '0);
    assign w_cmd_push = cmd_valid && cmd_ready;
    assign w_res_push = pushout && !stopin;
    assign w_res_pop  = res_valid && res_ready;
    assign w_can_load = (r_cmd_cnt != '0) && (r_out < c_OUT_MAX);
    assign w_cmd_head = r_cmd_mem[r_cmd_rp];
    assign w_res_head = r_res_mem[r_res_rp];

    // ---------------- command FIFO ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd_wp  <= '0;
            r_cmd_rp  <= '0;
            r_cmd_cnt <= '0;
        end else begin
            if (w_cmd_push) r_cmd_wp <= r_cmd_wp + c_CPTR_ONE;
            if (w_load)     r_cmd_rp <= r_cmd_rp + c_CPTR_ONE;
            case ({w_cmd_push, w_load})
                2'b10:   r_cmd_cnt <= r_cmd_cnt + c_CCNT_ONE;
                2'b01:   r_cmd_cnt <= r_cmd_cnt - c_CCNT_ONE;
                default: r_cmd_cnt <= r_cmd_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_cmd_push) r_cmd_mem[r_cmd_wp] <= {cmd_ctl, cmd_a, cmd_b, cmd_ci};
    end

    // ---------------- ALU-side output FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_load) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // Operands stay frozen until the ALU takes them.
                if (!stopout) begin
                    if (w_can_load) w_load      = 1'b1;
                    else            w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctl <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_ci  <= 1'b0;
        end else if (w_load) begin
            {r_ctl, r_a, r_b, r_ci} <= w_cmd_head;
        end
    end

    assign pushin = (r_state == S_DRIVE);
    assign ctl    = r_ctl;
    assign a      = r_a;
    assign b      = r_b;
    assign ci     = r_ci;

    // ---------------- in-flight tracking ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_res_push && (r_out == '0)) r_err <= 1'b1;
            if (w_load && !w_res_push)
                r_out <= r_out + c_OUT_ONE;
            else if (!w_load && w_res_push && (r_out != '0))
                r_out <= r_out - c_OUT_ONE;
        end
    end

    assign outstanding = r_out;
    assign err_unexp   = r_err;

    // ---------------- result FIFO ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res_wp  <= '0;
            r_res_rp  <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_res_push) r_res_wp <= r_res_wp + c_RPTR_ONE;
            if (w_res_pop)  r_res_rp <= r_res_rp + c_RPTR_ONE;
            case ({w_res_push, w_res_pop})
                2'b10:   r_res_cnt <= r_res_cnt + c_RCNT_ONE;
                2'b01:   r_res_cnt <= r_res_cnt - c_RCNT_ONE;
                default: r_res_cnt <= r_res_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_res_push) r_res_mem[r_res_wp] <= {cout, z};
    end

    // Gate the head with valid so an empty FIFO presents zeros.
    assign res_z    = res_valid ? w_res_head[DW-1:0] : '0;
    assign res_cout = res_valid ? w_res_head[DW]     : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_driver
// Brief    : Scoreboard bench for alu_op_driver with an ALU/consumer model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_op_driver;

    localparam int DW        = 8;
    localparam int CMD_DEPTH = 4;
    localparam int RES_DEPTH = 4;
    localparam int MAX_OUT   = 8;
    localparam int OW        = $clog2(MAX_OUT + 1);
    localparam int CW        = 2 * DW + 3;

    localparam int S_PUSHIN = 0, S_CMD_READY = 1, S_OUTST = 2, S_ERR = 3, S_STOPIN = 4,
                   S_RES_VALID = 5, S_RES_Z = 6, S_A = 7, S_B = 8, S_VAL = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_ctl = '0;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic          cmd_ci = 1'b0;
    logic          pushin;
    logic          stopout = 1'b0;
    logic [1:0]    ctl;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          ci;
    logic          pushout = 1'b0;
    logic          stopin;
    logic [DW-1:0] z = '0;
    logic          cout = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_z;
    logic          res_cout;
    logic [OW-1:0] outstanding;
    logic          err_unexp;

    alu_op_driver #(
        .DW(DW), .CMD_DEPTH(CMD_DEPTH), .RES_DEPTH(RES_DEPTH), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ctl(cmd_ctl),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ci(cmd_ci),
        .pushin(pushin), .stopout(stopout), .ctl(ctl), .a(a), .b(b), .ci(ci),
        .pushout(pushout), .stopin(stopin), .z(z), .cout(cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_cout(res_cout),
        .outstanding(outstanding), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          id;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    chk_t          dq[$];
    logic [CW-1:0] exp_cmd[$];
    logic [DW:0]   alu_pending[$];
    logic [DW:0]   exp_res[$];
    int            errors = 0;
    int            checks = 0;
    int            n_xin  = 0;

    // Reference ALU: add, subtract-with-carry, and, xor.
    function automatic logic [DW:0] alu_ref(input logic [CW-1:0] c);
        logic [1:0]    op;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic          cin;
        {op, x, y, cin} = c;
        case (op)
            2'd0:    return {1'b0, x} + {1'b0, y}  + {{DW{1'b0}}, cin};
            2'd1:    return {1'b0, x} + {1'b0, ~y} + {{DW{1'b0}}, cin};
            2'd2:    return {1'b0, x & y};
            default: return {cin, x ^ y};
        endcase
    endfunction

    function automatic logic [CW-1:0] mk(input int i);
        return {2'(i), DW'(i * 37 + 11), DW'(i * 5 + 1), 1'(i >> 1)};
    endfunction

    function automatic logic [31:0] sig(input int id);
        case (id)
            S_PUSHIN:    return 32'(pushin);
            S_CMD_READY: return 32'(cmd_ready);
            S_OUTST:     return 32'(outstanding);
            S_ERR:       return 32'(err_unexp);
            S_STOPIN:    return 32'(stopin);
            S_RES_VALID: return 32'(res_valid);
            S_RES_Z:     return 32'(res_z);
            S_A:         return 32'(a);
            S_B:         return 32'(b);
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] ev);
        checks++;
        if (act !== ev) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ev, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    chk_t          mc;
    logic [CW-1:0] me;
    logic [31:0]   mact;
    logic          prev_hold = 1'b0;
    logic [CW-1:0] prev_in = '0;

    initial forever begin
        @(negedge clk);
        check("res_valid_vs_model", 32'(res_valid), 32'(exp_res.size() != 0));
        check("stopin_vs_model", 32'(stopin), 32'(exp_res.size() == RES_DEPTH));
        if (rst && prev_hold) begin
            check("hold_pushin", 32'(pushin), 32'd1);
            check("hold_operands", 32'({ctl, a, b, ci}), 32'(prev_in));
        end
        while (dq.size() > 0) begin
            mc   = dq.pop_front();
            mact = (mc.id == S_VAL) ? mc.act : sig(mc.id);
            check(mc.name, mact, mc.exp);
        end
        if (rst) begin
            if (pushin && !stopout) begin
                n_xin++;
                check("alu_in_expected", 32'(exp_cmd.size() != 0), 32'd1);
                if (exp_cmd.size() != 0) begin
                    me = exp_cmd.pop_front();
                    check("alu_in_operands", 32'({ctl, a, b, ci}), 32'(me));
                    alu_pending.push_back(alu_ref(me));
                end
            end
            if (pushout && !stopin) begin
                exp_res.push_back({cout, z});
                if (alu_pending.size() != 0) void'(alu_pending.pop_front());
            end
            if (res_valid && res_ready) begin
                check("res_expected", 32'(exp_res.size() != 0), 32'd1);
                if (exp_res.size() != 0)
                    check("res_out", 32'({res_cout, res_z}), 32'(exp_res.pop_front()));
            end
        end
        prev_hold = rst && pushin && stopout;
        prev_in   = {ctl, a, b, ci};
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_sig(input string nm, input int id, input logic [31:0] ev);
        chk_t c;
        c.name = nm; c.id = id; c.act = '0; c.exp = ev;
        dq.push_back(c);
    endtask

    task automatic exp_val(input string nm, input logic [31:0] act, input logic [31:0] ev);
        chk_t c;
        c.name = nm; c.id = S_VAL; c.act = act; c.exp = ev;
        dq.push_back(c);
    endtask

    task automatic cycle_cmd(input bit vld, input logic [CW-1:0] c, output bit taken);
        cmd_valid = vld;
        {cmd_ctl, cmd_a, cmd_b, cmd_ci} = c;
        taken = vld && cmd_ready;
        if (taken) exp_cmd.push_back(c);
    endtask

    task automatic alu_drive(input bit en);
        if (en && alu_pending.size() > 0) begin
            pushout = 1'b1;
            {cout, z} = alu_pending[0];
        end else begin
            pushout = 1'b0;
            {cout, z} = '0;
        end
    endtask

    task automatic drain(input int n);
        cmd_valid = 1'b0;
        stopout   = 1'b0;
        for (int i = 0; i < n; i++) begin
            alu_drive(1'b1);
            res_ready = 1'b1;
            tick();
        end
        pushout   = 1'b0;
        res_ready = 1'b0;
    endtask

    bit tk;
    int acc;
    int n0;

    initial begin
        // Reset state
        tick(); tick();
        exp_sig("rst_pushin", S_PUSHIN, 0);
        exp_sig("rst_cmd_ready", S_CMD_READY, 1);
        exp_sig("rst_outstanding", S_OUTST, 0);
        exp_sig("rst_err", S_ERR, 0);
        exp_sig("rst_stopin", S_STOPIN, 0);
        exp_sig("rst_res_z", S_RES_Z, 0);
        exp_sig("rst_a", S_A, 0);
        tick();
        rst = 1'b1;
        tick();

        // Single op and latency
        cycle_cmd(1'b1, {2'd0, 8'h3C, 8'h05, 1'b0}, tk);
        exp_val("t1_accept", 32'(tk), 1);
        tick();
        cmd_valid = 1'b0;
        exp_sig("t1_pushin_edge_k", S_PUSHIN, 0);
        tick();
        exp_sig("t1_pushin", S_PUSHIN, 1);
        exp_sig("t1_a", S_A, 'h3C);
        exp_sig("t1_b", S_B, 'h05);
        exp_sig("t1_outstanding", S_OUTST, 1);
        tick();
        alu_drive(1'b1);
        exp_sig("t1_pushin_after", S_PUSHIN, 0);
        tick();
        alu_drive(1'b1);
        exp_sig("t1_res_valid", S_RES_VALID, 1);
        exp_sig("t1_res_z", S_RES_Z, 'h41);
        exp_sig("t1_outstanding_back", S_OUTST, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Stall hold
        stopout = 1'b1;
        n0 = n_xin;
        cycle_cmd(1'b1, {2'd0, 8'hFF, 8'h01, 1'b0}, tk);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            exp_sig("t2_pushin", S_PUSHIN, 1);
            exp_sig("t2_a", S_A, 'hFF);
            exp_sig("t2_b", S_B, 'h01);
            tick();
        end
        stopout = 1'b0;
        tick();
        exp_val("t2_transfers", 32'(n_xin - n0), 1);
        exp_sig("t2_pushin_after", S_PUSHIN, 0);
        exp_sig("t2_outstanding", S_OUTST, 1);
        drain(6);

        // Throughput and command-side full
        stopout = 1'b1;
        n0 = n_xin;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle_cmd(acc < 6, mk(acc), tk);
            tick();
            if (tk) acc++;
        end
        exp_val("t3_accepted_stalled", 32'(acc), 5);
        exp_sig("t3_cmd_ready_full", S_CMD_READY, 0);
        exp_sig("t3_outstanding_stalled", S_OUTST, 1);
        stopout = 1'b0;
        for (int j = 0; j < 6; j++) begin
            cycle_cmd(acc < 6, mk(acc), tk);
            tick();
            if (tk) acc++;
            exp_sig("t3_stream_pushin", S_PUSHIN, (j < 5) ? 1 : 0);
        end
        cmd_valid = 1'b0;
        exp_val("t3_transfers", 32'(n_xin - n0), 6);
        exp_sig("t3_outstanding", S_OUTST, 6);
        drain(20);

        // MAX_OUT limit
        n0 = n_xin;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            cycle_cmd(acc < 10, mk(acc + 8), tk);
            tick();
            if (tk) acc++;
        end
        cmd_valid = 1'b0;
        exp_val("t4_accepted", 32'(acc), 10);
        exp_val("t4_transfers", 32'(n_xin - n0), 8);
        exp_sig("t4_outstanding_max", S_OUTST, 8);
        exp_sig("t4_idle", S_PUSHIN, 0);
        alu_drive(1'b1);
        tick();
        alu_drive(1'b0);
        exp_sig("t4_outstanding_dec", S_OUTST, 7);
        exp_sig("t4_no_same_edge_load", S_PUSHIN, 0);
        tick();
        exp_sig("t4_ninth_load", S_PUSHIN, 1);
        exp_sig("t4_outstanding_reload", S_OUTST, 8);
        drain(40);
        exp_sig("t4_outstanding_end", S_OUTST, 0);

        // Result backpressure
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            cycle_cmd(acc < 5, mk(acc + 20), tk);
            tick();
            if (tk) acc++;
        end
        cmd_valid = 1'b0;
        exp_val("t5_pending", 32'(alu_pending.size()), 5);
        for (int i = 0; i < 6; i++) begin
            alu_drive(1'b1);
            tick();
        end
        exp_sig("t5_stopin_full", S_STOPIN, 1);
        exp_val("t5_fifth_held", 32'(alu_pending.size()), 1);
        exp_sig("t5_head", S_RES_Z, 32'(alu_ref(mk(20)) & {1'b0, {DW{1'b1}}}));
        res_ready = 1'b1;
        alu_drive(1'b1);
        tick();
        res_ready = 1'b0;
        exp_sig("t5_stopin_released", S_STOPIN, 0);
        exp_val("t5_still_held", 32'(alu_pending.size()), 1);
        alu_drive(1'b1);
        tick();
        exp_sig("t5_stopin_refull", S_STOPIN, 1);
        exp_val("t5_fifth_taken", 32'(alu_pending.size()), 0);
        drain(10);

        // Unexpected result
        exp_sig("t6_outstanding_zero", S_OUTST, 0);
        alu_pending.push_back({1'b1, 8'hA5});
        alu_drive(1'b1);
        tick();
        alu_drive(1'b0);
        exp_sig("t6_err_set", S_ERR, 1);
        exp_sig("t6_outstanding_stays", S_OUTST, 0);
        tick(); tick();
        exp_sig("t6_err_sticky", S_ERR, 1);
        drain(4);

        // Reset while driving
        stopout = 1'b1;
        cycle_cmd(1'b1, mk(40), tk);
        tick();
        cmd_valid = 1'b0;
        tick();
        exp_sig("t7_pushin_before", S_PUSHIN, 1);
        tick();
        #1;
        rst = 1'b0;
        exp_cmd.delete();
        exp_res.delete();
        alu_pending.delete();
        exp_sig("t7_pushin_async", S_PUSHIN, 0);
        exp_sig("t7_err_cleared", S_ERR, 0);
        exp_sig("t7_cmd_ready", S_CMD_READY, 1);
        exp_sig("t7_outstanding", S_OUTST, 0);
        exp_sig("t7_res_valid", S_RES_VALID, 0);
        stopout = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        alu_pending.push_back(alu_ref(mk(40)));
        alu_drive(1'b1);
        tick();
        alu_drive(1'b0);
        exp_sig("t7_late_result_err", S_ERR, 1);
        exp_sig("t7_late_outstanding", S_OUTST, 0);
        drain(4);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle_cmd($urandom_range(0, 9) < 6,
                      {2'($urandom_range(0, 3)), DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1))},
                      tk);
            stopout   = ($urandom_range(0, 9) < 3);
            alu_drive($urandom_range(0, 9) < 6);
            res_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        drain(80);
        exp_val("end_cmd_queue", 32'(exp_cmd.size()), 0);
        exp_val("end_alu_pending", 32'(alu_pending.size()), 0);
        exp_val("end_res_queue", 32'(exp_res.size()), 0);
        exp_sig("end_outstanding", S_OUTST, 0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_op_driver.md
Name: alu_op_driver

Overview:
- Initiator/consumer for the ALU push/stop protocol.
- Buffers upstream operation commands and presents them to the ALU's pushin/ctl/a/b/ci inputs, honouring stopout.
- Accepts ALU results on pushout/z/cout, applies backpressure via stopin, and buffers results for a downstream consumer.
- Tracks in-flight operations and flags unexpected results.

Parameters:
- DW, 8, operand/result width (a, b, z).
- CMD_DEPTH, 4, command FIFO entries (power of 2, >=2).
- RES_DEPTH, 4, result FIFO entries (power of 2, >=2).
- MAX_OUT, 8, maximum operations loaded-but-not-returned (>=1).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  upstream command present
- cmd_ready  out  1  command FIFO can accept
- cmd_ctl  in  2  operation select
- cmd_a  in  DW  operand a
- cmd_b  in  DW  operand b
- cmd_ci  in  1  carry-in
- pushin  out  1  operation valid to ALU
- stopout  in  1  ALU stall, operation not taken
- ctl  out  2  to ALU
- a  out  DW  to ALU
- b  out  DW  to ALU
- ci  out  1  to ALU
- pushout  in  1  ALU result valid
- stopin  out  1  stall to ALU result side
- z  in  DW  ALU result
- cout  in  1  ALU carry-out
- res_valid  out  1  result FIFO non-empty
- res_ready  in  1  downstream pop
- res_z  out  DW  head result
- res_cout  out  1  head carry
- outstanding  out  $clog2(MAX_OUT+1)  loaded-not-returned count
- err_unexp  out  1  sticky: result received with outstanding==0

Behaviour:
- Transfer rules:
  - ALU input side transfers on an edge where pushin=1 and stopout=0.
  - ALU output side transfers on an edge where pushout=1 and stopin=0.
  - Upstream accepts on cmd_valid&&cmd_ready.
  - Downstream pops on res_valid&&res_ready.
- Reset (rst=0, async): both FIFOs empty, FSM=IDLE, pushin=0, ctl/a/b/ci=0, stopin=0, cmd_ready=1, res_valid=0, res_z/res_cout=0, outstanding=0, err_unexp=0.
- Command FIFO:
  - cmd_ready = count<CMD_DEPTH, from registered count; no same-cycle bypass of a pop.
  - Pointers wrap modulo CMD_DEPTH.
- ALU output register FSM:
  - IDLE: pushin=0. Go to DRIVE when the FIFO is non-empty and outstanding<MAX_OUT. On that edge the head loads into ctl/a/b/ci, is popped, and outstanding increments.
  - DRIVE: pushin=1. ctl/a/b/ci stay stable while stopout=1; pushin is never withdrawn before a transfer.
  - On a transfer edge in DRIVE: if the FIFO is non-empty and outstanding<MAX_OUT, load the next command and stay in DRIVE (back-to-back, one op per cycle). Otherwise go to IDLE.
- Latency: a command accepted at edge k into an empty FIFO with FSM IDLE gives pushin=1 after edge k+1.
- Result FIFO and backpressure:
  - stopin = (res count == RES_DEPTH), from the registered count. A pop in the same cycle does not clear stopin until the next edge.
  - res_z/res_cout show the head entry. Pointers wrap modulo RES_DEPTH.
- outstanding:
  - +1 on load, -1 on an ALU result transfer.
  - Simultaneous load and result leaves it unchanged.
  - A result when outstanding==0: result is stored, outstanding stays 0, err_unexp sets and holds until reset.
- MAX_OUT reached: no load. FSM sits in IDLE until a result returns; the load happens on the edge after the result transfer.
- Reset mid-operation: state clears immediately and pushin drops asynchronously. Results the ALU delivers afterward set err_unexp.

Test Plan:
- Single op: after reset push ctl=0, a=8'h3C, b=8'h05, ci=0. Require pushin=1 after edge k+1 with a=3C, b=05. Return z=8'h41, cout=0 → res_valid=1, res_z=41, outstanding back to 0.
- Stall hold: stopout=1 for 5 cycles with a=8'hFF, b=8'h01 driven → pushin, ctl, a, b, ci constant all 5 cycles. One transfer after stopout falls; outstanding=1.
- Throughput/full: 6 commands with stopout=1 → cmd_ready falls after 4 FIFO entries plus 1 in the output register. Release stopout → 5 consecutive-cycle transfers, then the 6th.
- MAX_OUT=8 limit: 10 commands with no results → exactly 8 transfers, FSM IDLE, outstanding=8. One result → 9th load on the following edge.
- Result backpressure: res_ready=0 and 4 results → stopin=1 with 4 entries. A 5th pushout is held, not lost. One pop → stopin=0 next edge; the 5th result is taken and order is preserved.
- Unexpected/reset: pushout with outstanding=0 → err_unexp=1 and sticky. Assert rst while pushin=1 → pushin=0 immediately, err_unexp=0, FIFOs empty.
